// File: rtl/riscv_dmem_pkg.sv
// riscv_dmem_pkg: shared FSM/error types and address-split helpers for the data-memory model
// Contents: dmem_state_e (model FSM), err_kind_e (error classes), off_w()/idx_w() sizing helpers
package riscv_dmem_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} dmem_state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_RDWR} err_kind_e;
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/riscv_dmem_bank.sv
// riscv_dmem_bank: DEPTH x DATA_W storage with byte-lane writes and a registered read port
// Ports: clk; we/be/wdata write one word at idx; re registers mem[idx] into rdata, which holds otherwise
module riscv_dmem_bank import riscv_dmem_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_W / 8; k++)
            if (we && be[k]) mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/riscv_dmem_model.sv
// riscv_dmem_model: cycle-accurate data-memory model with read latency, write wait states and error flagging
// Ports: clk, rst_n (sync, active-low); request i_rd_en/i_wr_en/i_addr/i_wdata/i_be accepted when o_ready;
//        response o_rdata/o_rvalid (one-cycle strobe), o_err (one-cycle strobe for a rejected access)
module riscv_dmem_model import riscv_dmem_pkg::*; #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int WR_WAIT    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rd_en,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_be,
    output logic                o_ready,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_rvalid,
    output logic                o_err
);
    localparam int OFF_W = off_w(DATA_W);
    localparam int IDX_W = idx_w(DEPTH);
    localparam int MAX_C = RD_LATENCY > WR_WAIT ? RD_LATENCY : WR_WAIT;
    localparam int CNT_W = $clog2(MAX_C + 1);
    if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        RD_LATENCY < 1 || RD_LATENCY > 8 || WR_WAIT < 0 || WR_WAIT > 8 || OFF_W + IDX_W > ADDR_W) begin : g_bad_param
        $fatal(1, "riscv_dmem_model: illegal parameter value");
    end
    dmem_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic              rvalid_q, err_q, acc, bad, rd_ok, wr_ok;
    logic [DATA_W-1:0] bank_rdata;
    // Out of range reduces to "any address bit above the word index is set" since DEPTH is a power of two.
    assign bad   = (i_rd_en & i_wr_en) | (|(i_addr & ADDR_W'(DATA_W / 8 - 1))) | (|(i_addr >> (OFF_W + IDX_W)));
    assign acc   = (i_rd_en | i_wr_en) & o_ready;
    assign rd_ok = acc & i_rd_en & ~bad;
    assign wr_ok = acc & i_wr_en & ~bad;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = (rvalid_q && !err_q) ? bank_rdata : '0;
    riscv_dmem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
        .clk   (clk),
        .we    (wr_ok),
        .re    (rd_ok),
        .idx   (i_addr[OFF_W +: IDX_W]),
        .wdata (i_wdata),
        .be    (i_be),
        .rdata (bank_rdata)
    );
    // Wait states finish when cnt reaches 1 (then cleared), so the counter never wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_ready  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            o_err    <= 1'b0;
            if (state == IDLE) begin
                o_ready <= 1'b1;
                if (acc && i_wr_en) begin
                    o_err <= bad;
                    if (WR_WAIT > 0) begin
                        state   <= riscv_dmem_pkg::WR_WAIT;
                        cnt     <= CNT_W'(WR_WAIT);
                        o_ready <= 1'b0;
                    end
                end else if (acc) begin
                    err_q <= bad;
                    if (RD_LATENCY == 1) begin
                        rvalid_q <= 1'b1;
                        o_err    <= bad;
                    end else begin
                        state   <= RD_WAIT;
                        cnt     <= CNT_W'(RD_LATENCY - 1);
                        o_ready <= 1'b0;
                    end
                end
            end else if (cnt <= CNT_W'(1)) begin
                state    <= IDLE;
                cnt      <= '0;
                o_ready  <= 1'b1;
                rvalid_q <= (state == RD_WAIT);
                o_err    <= (state == RD_WAIT) && err_q;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_model.sv
// tb_riscv_dmem_model: directed checks of three model configurations sharing one request bus
module tb_riscv_dmem_model;
    logic        clk = 1'b0;
    logic        rst_n, rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rdy_a, rv_a, er_a, rdy_b, rv_b, er_b, rdy_c, rv_c, er_c;
    logic [31:0] rd_a, rd_b, rd_c;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    riscv_dmem_model #(.RD_LATENCY(3), .WR_WAIT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_rd_en(rd_en), .i_wr_en(wr_en), .i_addr(addr), .i_wdata(wdata),
        .i_be(be), .o_ready(rdy_a), .o_rdata(rd_a), .o_rvalid(rv_a), .o_err(er_a));
    riscv_dmem_model #(.RD_LATENCY(1), .WR_WAIT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_rd_en(rd_en), .i_wr_en(wr_en), .i_addr(addr), .i_wdata(wdata),
        .i_be(be), .o_ready(rdy_b), .o_rdata(rd_b), .o_rvalid(rv_b), .o_err(er_b));
    riscv_dmem_model #(.RD_LATENCY(4), .WR_WAIT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_rd_en(rd_en), .i_wr_en(wr_en), .i_addr(addr), .i_wdata(wdata),
        .i_be(be), .o_ready(rdy_c), .o_rdata(rd_c), .o_rvalid(rv_c), .o_err(er_c));

    // One-cycle request; returns at the negedge right after the acceptance edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wdata = d; be = b;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({rdy_a, rdy_b, rdy_c, rv_a, rv_b, rv_c, er_a, er_b, er_c} !== 9'b0) begin
                fails++; $display("FAIL reset_outputs: got %b required 000000000", {rdy_a, rdy_b, rdy_c, rv_a, rv_b, rv_c, er_a, er_b, er_c});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin fails++; $display("FAIL reset_ready_rise: got %b required 111", {rdy_a, rdy_b, rdy_c}); end
        checks++;
        if ({rv_a, er_a, rd_a} !== 34'b0) begin fails++; $display("FAIL reset_idle_resp: got %h required 0", {rv_a, er_a, rd_a}); end
    endtask

    task automatic test_basic;
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({rdy_a, er_a} !== 2'b10) begin fails++; $display("FAIL basic_write_nowait: got %b required 10", {rdy_a, er_a}); end
        idle(3);
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        checks++;
        if ({rdy_a, rv_a} !== 2'b00) begin fails++; $display("FAIL basic_wait1: got %b required 00", {rdy_a, rv_a}); end
        @(negedge clk);
        checks++;
        if ({rdy_a, rv_a} !== 2'b00) begin fails++; $display("FAIL basic_wait2: got %b required 00", {rdy_a, rv_a}); end
        @(negedge clk);
        checks++;
        if ({rdy_a, rv_a, er_a} !== 3'b110) begin fails++; $display("FAIL basic_rvalid: got %b required 110", {rdy_a, rv_a, er_a}); end
        checks++;
        if (rd_a !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rdata: got %h required deadbeef", rd_a); end
        @(negedge clk);
        checks++;
        if ({rv_a, rd_a} !== 33'b0) begin fails++; $display("FAIL basic_rdata_clear: got %h required 0", {rv_a, rd_a}); end
        idle(3);
    endtask

    task automatic test_byte_enable;
        req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF); idle(3);
        req(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5); idle(3);
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        checks++;
        if ({rv_b, rd_b} !== {1'b1, 32'h11BB33DD}) begin fails++; $display("FAIL be_merge_b: got %b/%h required 1/11bb33dd", rv_b, rd_b); end
        idle(2);
        checks++;
        if ({rv_a, rd_a} !== {1'b1, 32'h11BB33DD}) begin fails++; $display("FAIL be_merge_a: got %b/%h required 1/11bb33dd", rv_a, rd_a); end
        idle(3);
        req(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0); idle(3);
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        checks++;
        if ({rv_b, rd_b} !== {1'b1, 32'h11BB33DD}) begin fails++; $display("FAIL be_zero_noop: got %b/%h required 1/11bb33dd", rv_b, rd_b); end
        idle(4);
    endtask

    task automatic test_errors;
        logic seen;
        req(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF); idle(3);
        req(1'b0, 1'b1, 32'h4, 32'h44444444, 4'hF); idle(3);
        req(1'b0, 1'b1, 32'hFFC, 32'h600DCAFE, 4'hF); idle(3);
        req(1'b1, 1'b0, 32'h1002, 32'h0, 4'h0);
        checks++;
        if ({rv_b, er_b, rd_b} !== {2'b11, 32'h0}) begin fails++; $display("FAIL err_rd_b: got %b%b/%h required 11/0", rv_b, er_b, rd_b); end
        checks++;
        if ({rdy_a, rv_a, er_a} !== 3'b000) begin fails++; $display("FAIL err_rd_a_early: got %b required 000", {rdy_a, rv_a, er_a}); end
        idle(2);
        checks++;
        if ({rv_a, er_a, rd_a} !== {2'b11, 32'h0}) begin fails++; $display("FAIL err_rd_a: got %b%b/%h required 11/0", rv_a, er_a, rd_a); end
        idle(3);
        req(1'b1, 1'b0, 32'h6, 32'h0, 4'h0);
        checks++;
        if ({rv_b, er_b, rd_b} !== {2'b11, 32'h0}) begin fails++; $display("FAIL err_misalign: got %b%b/%h required 11/0", rv_b, er_b, rd_b); end
        idle(4);
        req(1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
        checks++;
        if ({rv_b, er_b, rd_b} !== {2'b10, 32'h600DCAFE}) begin fails++; $display("FAIL last_word: got %b%b/%h required 10/600dcafe", rv_b, er_b, rd_b); end
        idle(4);
        req(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        checks++;
        if ({er_a, er_b, rdy_b} !== 3'b110) begin fails++; $display("FAIL err_wr: got %b required 110", {er_a, er_b, rdy_b}); end
        idle(4);
        req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if ({rv_b, er_b, rd_b} !== {2'b10, 32'h0BADF00D}) begin fails++; $display("FAIL err_wr_dropped: got %b%b/%h required 10/0badf00d", rv_b, er_b, rd_b); end
        idle(4);
        req(1'b1, 1'b1, 32'h4, 32'h99999999, 4'hF);
        checks++;
        if ({er_a, er_b} !== 2'b11) begin fails++; $display("FAIL err_rdwr: got %b required 11", {er_a, er_b}); end
        seen = rv_a | rv_b | rv_c;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | rv_a | rv_b | rv_c;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL err_rdwr_no_rvalid: got %b required 0", seen); end
        req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        checks++;
        if (rd_b !== 32'h44444444) begin fails++; $display("FAIL err_rdwr_dropped: got %h required 44444444", rd_b); end
        idle(4);
    endtask

    task automatic test_back_to_back;
        int hits;
        for (int i = 0; i < 16; i++) begin
            req(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
            idle(3);
        end
        @(negedge clk);
        rd_en = 1'b1; addr = 32'h100;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rv_b === 1'b1 && rdy_b === 1'b1 && rd_b === 32'hC0DE0000 + 32'(i)) hits++;
            addr = 32'h100 + 32'(4 * (i + 1));
        end
        rd_en = 1'b0;
        checks++;
        if (hits !== 16) begin fails++; $display("FAIL b2b_reads: got %0d required 16", hits); end
        @(negedge clk);
        checks++;
        if (rv_b !== 1'b0) begin fails++; $display("FAIL b2b_stop: got %b required 0", rv_b); end
        idle(6);
    endtask

    task automatic test_write_wait;
        logic [5:0] seen;
        @(negedge clk);
        wr_en = 1'b1; addr = 32'h200; wdata = 32'h5A5A5A5A; be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen[5-i] = rdy_b;
        end
        wr_en = 1'b0;
        checks++;
        if (seen !== 6'b001001) begin fails++; $display("FAIL wr_wait_ready: got %b required 001001", seen); end
        idle(3);
        req(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        checks++;
        if ({rv_b, er_b, rd_b} !== {2'b10, 32'h5A5A5A5A}) begin fails++; $display("FAIL wr_wait_data: got %b%b/%h required 10/5a5a5a5a", rv_b, er_b, rd_b); end
        idle(4);
    endtask

    task automatic test_reset_mid_read;
        logic seen;
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        seen = rv_c;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | rv_c;
            if (i == 1) rst_n = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL mid_reset_abort: got %b required 0", seen); end
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        idle(3);
        checks++;
        if ({rv_c, rd_c} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL mid_reset_reread: got %b/%h required 1/deadbeef", rv_c, rd_c); end
        idle(2);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_byte_enable;
        test_errors;
        test_back_to_back;
        test_write_wait;
        test_reset_mid_read;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
